// File: rtl/tdm_demux4.sv
// tdm_demux4: receive end of a 4-slot TDM lane.
// Locks to the slot-0 sync marker and assembles one 4-channel word per frame.
// A missing sync is tolerated (flywheel) until MISS_MAX consecutive misses drop lock.
module tdm_demux4 #(
   parameter int unsigned W        = 1,
   parameter int unsigned MISS_MAX = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   input  logic           sync,
   input  logic [W-1:0]   in,
   output logic [4*W-1:0] out,
   output logic           valid,
   output logic [1:0]     sel,
   output logic           locked,
   output logic           err
);

   localparam int unsigned SHW      = 3 * W;
   localparam logic [3:0]  MISS_LIM = 4'(MISS_MAX);

   typedef enum logic {
      ST_HUNT = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

   state_t           r_state;
   logic [SHW-1:0]   r_shadow;
   logic [3:0]       r_miss;
   logic [1:0]       r_sel;
   logic [4*W-1:0]   r_out;
   logic             r_valid;
   logic             r_err;

   state_t           w_state_nxt;
   logic [SHW-1:0]   w_shadow_nxt;
   logic [3:0]       w_miss_nxt;
   logic [1:0]       w_sel_nxt;
   logic [4*W-1:0]   w_out_nxt;
   logic             w_valid_nxt;
   logic             w_err_nxt;
   logic [3:0]       w_miss_inc;

   assign w_miss_inc = r_miss + 4'd1;

   // State and datapath registers; reset clears everything, discarding any partial frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_HUNT;
         r_shadow <= '0;
         r_miss   <= '0;
         r_sel    <= '0;
         r_out    <= '0;
         r_valid  <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_shadow <= w_shadow_nxt;
         r_miss   <= w_miss_nxt;
         r_sel    <= w_sel_nxt;
         r_out    <= w_out_nxt;
         r_valid  <= w_valid_nxt;
         r_err    <= w_err_nxt;
      end
   end

   // Next-state: slot tracking, sync checking and word assembly on each en sample.
   always_comb begin
      w_state_nxt  = r_state;
      w_shadow_nxt = r_shadow;
      w_miss_nxt   = r_miss;
      w_sel_nxt    = r_sel;
      w_out_nxt    = r_out;
      w_valid_nxt  = 1'b0;
      w_err_nxt    = 1'b0;

      if (en) begin
         case (r_state)
            ST_HUNT: begin
               if (sync) begin
                  w_shadow_nxt[0 +: W] = in;
                  w_sel_nxt            = 2'd1;
                  w_miss_nxt           = 4'd0;
                  w_state_nxt          = ST_LOCK;
               end
            end
            ST_LOCK: begin
               if (sync && (r_sel != 2'd0)) begin
                  // Early sync: abandon the partial frame and restart at slot 0.
                  w_err_nxt            = 1'b1;
                  w_shadow_nxt[0 +: W] = in;
                  w_sel_nxt            = 2'd1;
                  w_miss_nxt           = 4'd0;
               end else begin
                  case (r_sel)
                     2'd0: begin
                        if (sync) begin
                           w_shadow_nxt[0 +: W] = in;
                           w_sel_nxt            = 2'd1;
                           w_miss_nxt           = 4'd0;
                        end else if (w_miss_inc == MISS_LIM) begin
                           w_sel_nxt   = 2'd0;
                           w_miss_nxt  = 4'd0;
                           w_state_nxt = ST_HUNT;
                        end else begin
                           w_shadow_nxt[0 +: W] = in;
                           w_sel_nxt            = 2'd1;
                           w_miss_nxt           = w_miss_inc;
                        end
                     end
                     2'd1: begin
                        w_shadow_nxt[W +: W] = in;
                        w_sel_nxt            = 2'd2;
                     end
                     2'd2: begin
                        w_shadow_nxt[2*W +: W] = in;
                        w_sel_nxt              = 2'd3;
                     end
                     default: begin
                        w_out_nxt   = {in, r_shadow};
                        w_valid_nxt = 1'b1;
                        w_sel_nxt   = 2'd0;
                     end
                  endcase
               end
            end
            default: w_state_nxt = ST_HUNT;
         endcase
      end
   end

   assign out    = r_out;
   assign valid  = r_valid;
   assign sel    = r_sel;
   assign err    = r_err;
   assign locked = (r_state == ST_LOCK);

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: randomized and directed checks against a frame-level queue model.
module tb_tdm_demux4;

   localparam int unsigned W        = 1;
   localparam int unsigned MISS_MAX = 2;

   logic           clk;
   logic           rst_n;
   logic           en;
   logic           sync;
   logic [W-1:0]   in;
   logic [4*W-1:0] out;
   logic           valid;
   logic [1:0]     sel;
   logic           locked;
   logic           err;

   int n_total;
   int n_bad;

   // Reference model: collected samples of the frame in progress.
   logic [W-1:0]   q[$];
   logic           m_locked;
   int             m_miss;
   logic [4*W-1:0] m_out;
   logic           m_valid;
   logic           m_err;

   tdm_demux4 #(.W(W), .MISS_MAX(MISS_MAX)) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .sync   (sync),
      .in     (in),
      .out    (out),
      .valid  (valid),
      .sel    (sel),
      .locked (locked),
      .err    (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_locked = 1'b0;
      m_miss   = 0;
      m_out    = '0;
      m_valid  = 1'b0;
      m_err    = 1'b0;
   endtask

   task automatic model_sample(input logic e, input logic s, input logic [W-1:0] d);
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (e) begin
         if (!m_locked) begin
            if (s) begin
               m_locked = 1'b1;
               q = {d};
               m_miss = 0;
            end
         end else if (q.size() == 0) begin
            if (s) begin
               q = {d};
               m_miss = 0;
            end else begin
               m_miss++;
               if (m_miss == int'(MISS_MAX)) begin
                  m_locked = 1'b0;
                  m_miss   = 0;
               end else begin
                  q = {d};
               end
            end
         end else if (s) begin
            m_err = 1'b1;
            q = {d};
            m_miss = 0;
         end else begin
            q.push_back(d);
            if (q.size() == 4) begin
               for (int k = 0; k < 4; k++) m_out[k*W +: W] = q[k];
               m_valid = 1'b1;
               q.delete();
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".out"},    32'(out),    32'(m_out));
      check({tag, ".valid"},  32'(valid),  32'(m_valid));
      check({tag, ".sel"},    32'(sel),    32'(q.size()));
      check({tag, ".locked"}, 32'(locked), 32'(m_locked));
      check({tag, ".err"},    32'(err),    32'(m_err));
   endtask

   // One clock: drive inputs, clock the model alongside the DUT, compare after the edge.
   task automatic step(input string tag, input logic e, input logic s, input logic [W-1:0] d);
      en   = e;
      sync = s;
      in   = d;
      @(posedge clk);
      model_sample(e, s, d);
      #1;
      check_all(tag);
   endtask

   task automatic frame(input string tag, input logic s0, input logic [3:0] bits, input int gap);
      for (int k = 0; k < 4; k++) begin
         step(tag, 1'b1, (k == 0) ? s0 : 1'b0, W'(bits[k]));
         for (int g = 0; g < gap; g++) step(tag, 1'b0, 1'b0, W'($urandom));
      end
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      rst_n   = 1'b0;
      en      = 1'b0;
      sync    = 1'b0;
      in      = '0;
      model_reset();

      #12;
      check_all("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Hunt filtering
      for (int i = 0; i < 7; i++) step("hunt", 1'b1, 1'b0, W'($urandom));
      check("hunt_out", 32'(out), 32'h0);

      // Baseline frame
      frame("base", 1'b1, 4'b1101, 0);
      check("base_word", 32'(out), 32'hD);
      check("base_valid", 32'(valid), 32'h1);
      step("base_idle", 1'b0, 1'b0, '0);

      // Gapped strobe
      frame("gap", 1'b1, 4'b1101, 2);
      check("gap_word", 32'(out), 32'hD);

      // Early sync at slot 2, then frame 0,1,1,0 starting from that sample
      step("early", 1'b1, 1'b1, W'(1));
      step("early", 1'b1, 1'b0, W'(1));
      step("early", 1'b1, 1'b1, W'(0));
      check("early_err", 32'(err), 32'h1);
      check("early_sel", 32'(sel), 32'h1);
      step("early", 1'b1, 1'b0, W'(1));
      step("early", 1'b1, 1'b0, W'(1));
      step("early", 1'b1, 1'b0, W'(0));
      check("early_word", 32'(out), 32'h6);

      // Flywheel then loss of lock
      frame("fly1", 1'b0, 4'b0101, 0);
      check("fly_word", 32'(out), 32'h5);
      step("fly2", 1'b1, 1'b0, W'(1));
      check("fly_unlock", 32'(locked), 32'h0);
      for (int i = 0; i < 6; i++) step("fly2", 1'b1, 1'b0, W'($urandom));

      // Reset mid-frame, checked before any clock edge
      frame("pre_rst", 1'b1, 4'b1111, 0);
      step("mid", 1'b1, 1'b1, W'(1));
      step("mid", 1'b1, 1'b0, W'(0));
      #1 rst_n = 1'b0;
      model_reset();
      #1 check_all("async_rst");
      @(posedge clk);
      #1 check_all("rst_held");
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) step("post_rst", 1'b1, 1'b0, W'($urandom));

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic e, s;
         e = ($urandom_range(0, 9) < 7);
         s = (q.size() == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 29) == 0);
         step("rand", e, s, W'($urandom));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
